// File: rtl/global_avg_pool_pkg.sv
// Shared definitions for the classifier's global-average-pool stage.
// The state encodings are also used by max_layer.
package global_avg_pool_pkg;

  localparam int DEF_BIT_SIZE    = 8;
  localparam int DEF_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } gap_state_t;

  // The accumulator needs enough headroom that a full frame of maximum scores never wraps.
  function automatic int acc_width(input int bit_size, input int pool_size);
    return bit_size + $clog2(pool_size);
  endfunction

endpackage

// File: rtl/global_avg_pool_gap_lane.sv
// One class lane: accumulate a frame of scores, then round-shift and saturate
// the final sum into the registered lane output.
module gap_lane
  import global_avg_pool_pkg::*;
#(
  parameter int BIT_SIZE  = DEF_BIT_SIZE,
  parameter int POOL_SIZE = 36,
  parameter int SHIFT     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                add,
  input  logic                fin,
  input  logic [BIT_SIZE-1:0] din,
  output logic [BIT_SIZE-1:0] dout
);

  localparam int ACC_W = acc_width(BIT_SIZE, POOL_SIZE);
  // Half of the divisor; evaluates to 0 when SHIFT is 0, so avg() degenerates to a plain pass-through.
  localparam int RND_I = (2 ** SHIFT) / 2;
  localparam logic [ACC_W:0] RND  = (ACC_W + 1)'(RND_I);
  localparam logic [ACC_W:0] MAXV = (ACC_W + 1)'((2 ** BIT_SIZE) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_nxt;

  function automatic logic [ACC_W:0] avg(input logic [ACC_W-1:0] s);
    logic [ACC_W:0] r;
    r = {1'b0, s} + RND;
    return r >> SHIFT;
  endfunction

  function automatic logic [BIT_SIZE-1:0] sat(input logic [ACC_W:0] x);
    return (x > MAXV) ? {BIT_SIZE{1'b1}} : x[BIT_SIZE-1:0];
  endfunction

  // The final beat is folded in here, so the result does not wait a cycle for acc to update.
  always_comb begin
    sum_nxt = load ? ACC_W'(din) : acc + ACC_W'(din);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (load || add) acc <= sum_nxt;
      if (fin)         dout <= sat(avg(sum_nxt));
    end
  end

endmodule

// File: rtl/global_avg_pool.sv
// Global average pool: averages POOL_SIZE beats per class and hands the
// packed score vector to max_layer with a valid/ready handshake.
module global_avg_pool
  import global_avg_pool_pkg::*;
#(
  parameter int BIT_SIZE    = DEF_BIT_SIZE,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int POOL_SIZE   = 36,
  parameter int SHIFT       = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_SIZE*NUM_CLASSES-1:0] in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BIT_SIZE*NUM_CLASSES-1:0] out,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int CNT_W = $clog2(POOL_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);

  gap_state_t       state;
  gap_state_t       state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             last_beat;
  logic             lane_load;
  logic             lane_add;
  logic             lane_fin;

  assign accept = in_valid && in_ready;

  // A single-beat frame completes straight from IDLE.
  always_comb begin
    last_beat = (state == S_IDLE) ? 1'(POOL_SIZE == 1) : (beat_cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = last_beat ? S_OUTPUT : S_ACCUM;
      S_ACCUM:  if (accept && last_beat) state_nxt = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != S_OUTPUT);
    out_valid = (state == S_OUTPUT);
    lane_load = accept && (state == S_IDLE);
    lane_add  = accept && (state == S_ACCUM);
    lane_fin  = accept && last_beat;
  end

  always_ff @(posedge clk) begin
    if (rst)         beat_cnt <= '0;
    else if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
  end

  // Class 0 sits in the most significant slice of both in and out.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
    gap_lane #(
      .BIT_SIZE (BIT_SIZE),
      .POOL_SIZE(POOL_SIZE),
      .SHIFT    (SHIFT)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .load(lane_load),
      .add (lane_add),
      .fin (lane_fin),
      .din (in[(NUM_CLASSES-1-c)*BIT_SIZE +: BIT_SIZE]),
      .dout(out[(NUM_CLASSES-1-c)*BIT_SIZE +: BIT_SIZE])
    );
  end

endmodule
